// File: rtl/rv32_enc_pkg.sv
// Shared RV32I encoder definitions: instruction type codes, opcodes and the
// field bundle handed from the loader to the packer.
package rv32_enc_pkg;

    typedef enum logic [3:0] {
        IT_NONE  = 4'd0,
        IT_LOAD  = 4'd1,
        IT_STORE = 4'd2,
        IT_RTYPE = 4'd3,
        IT_IALU  = 4'd4
    } inst_type_e;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } load_state_e;

    typedef struct packed {
        inst_type_e  itype;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic [11:0] imm;
    } fields_t;

endpackage

// File: rtl/inst_packer.sv
// Combinational field-to-word RV32I encoder; unknown types become a NOP and
// raise unsup_o.
module inst_packer
    import rv32_enc_pkg::*;
(
    input  fields_t     f_i,
    output logic [31:0] word_o,
    output logic        unsup_o
);

    always_comb begin
        word_o  = NOP;
        unsup_o = 1'b0;
        case (f_i.itype)
            IT_LOAD:  word_o = {f_i.imm, f_i.rs1, f_i.func3, f_i.rd, OPC_LOAD};
            IT_STORE: word_o = {f_i.imm[11:5], f_i.rs2, f_i.rs1, f_i.func3,
                                f_i.imm[4:0], OPC_STORE};
            IT_RTYPE: word_o = {f_i.func7, f_i.rs2, f_i.rs1, f_i.func3, f_i.rd, OPC_OP};
            IT_IALU: begin
                // Shift-immediates carry funct7 in the upper immediate bits
                if (f_i.func3 == 3'b001 || f_i.func3 == 3'b101)
                    word_o = {f_i.func7, f_i.imm[4:0], f_i.rs1, f_i.func3, f_i.rd, OPC_OPIMM};
                else
                    word_o = {f_i.imm, f_i.rs1, f_i.func3, f_i.rd, OPC_OPIMM};
            end
            default:  unsup_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/inst_encoder_loader.sv
// Streams decoded instruction bundles into instruction memory as packed RV32I
// words, one word per cycle, behind a single output register stage.
module inst_encoder_loader
    import rv32_enc_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0,
    localparam int CNT_W    = $clog2(DEPTH + 1)
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [3:0]        inst_type,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        func3,
    input  logic [6:0]        func7,
    input  logic [11:0]       immediate,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic              err
);

    load_state_e       state_q, state_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q, wptr_q;
    logic [31:0]       wdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_q;

    fields_t           fields;
    logic [31:0]       word;
    logic              unsup;
    logic [CNT_W:0]    occ;
    logic              full, ready, xfer, sess_start;

    assign fields = '{itype: inst_type_e'(inst_type), rd: rd, rs1: rs1, rs2: rs2,
                      func3: func3, func7: func7, imm: immediate};

    inst_packer u_packer (
        .f_i     (fields),
        .word_o  (word),
        .unsup_o (unsup)
    );

    // Occupancy counts the word still sitting in the output register
    always_comb begin
        occ        = {1'b0, cnt_q} + (CNT_W+1)'(we_q);
        full       = (occ == (CNT_W+1)'(DEPTH));
        ready      = (state_q == LOAD) && !full;
        xfer       = in_valid && ready;
        sess_start = (state_q == IDLE) && start;
    end

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            IDLE:  if (start) state_d = LOAD;
            LOAD:  if (xfer && (in_last || (occ + (CNT_W+1)'(1)) == (CNT_W+1)'(DEPTH)))
                       state_d = FLUSH;
            FLUSH: if (!we_q) begin
                       done    = 1'b1;
                       state_d = IDLE;
                   end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= ADDR_W'(BASE_ADDR);
            wptr_q  <= ADDR_W'(BASE_ADDR);
            wdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= xfer;
            if (sess_start) begin
                cnt_q  <= '0;
                err_q  <= 1'b0;
                addr_q <= ADDR_W'(BASE_ADDR);
                wptr_q <= ADDR_W'(BASE_ADDR);
            end else begin
                cnt_q <= cnt_q + CNT_W'(we_q);
            end
            if (xfer) begin
                addr_q  <= wptr_q;
                wptr_q  <= wptr_q + ADDR_W'(4);
                wdata_q <= word;
                if (unsup) err_q <= 1'b1;
            end
        end
    end

    assign in_ready   = ready;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = cnt_q;
    assign busy       = (state_q != IDLE);
    assign err        = err_q;

endmodule

// File: doc/inst_encoder_loader.md
Name: inst_encoder_loader

Overview:
Inverse of the instruction decoder. Accepts decoded instruction fields (inst_type, rd, rs1, rs2, func3, func7, 12-bit immediate) over a valid/ready stream and packs each into a 32-bit RV32I word. Writes the words sequentially into instruction memory. Used by the bench/boot path to load programs before the single-cycle core is released from reset.

Parameters:
ADDR_W, 10, byte-address width of instruction memory port
DEPTH, 256, capacity in 32-bit words; must be <= 2**(ADDR_W-2)
BASE_ADDR, 0, byte address of first written word; word-aligned

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start  input  1  pulse; begins a load session from BASE_ADDR
in_valid  input  1  field bundle valid
in_ready  output  1  block can accept a bundle this cycle
in_last  input  1  bundle is final instruction of program
inst_type  input  4  encoder type code (package enum)
rd  input  5  destination register
rs1  input  5  source register 1
rs2  input  5  source register 2
func3  input  3  funct3 field
func7  input  7  funct7 field
immediate  input  12  12-bit immediate
imem_we  output  1  instruction-memory write strobe
imem_addr  output  ADDR_W  byte write address
imem_wdata  output  32  encoded instruction
count  output  $clog2(DEPTH+1)  words written this session
busy  output  1  session active
done  output  1  one-cycle pulse when session ends
err  output  1  sticky; unsupported inst_type seen this session

Behaviour:
- Reset: state IDLE; in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, count=0, busy=0, done=0, err=0.
- Reset is honoured mid-session: pending write is dropped and memory contents are left as-is.
- FSM states: IDLE, LOAD, FLUSH.
  - IDLE: start -> LOAD; clears count and err, sets write pointer = BASE_ADDR.
  - LOAD: in_ready = !full, where full means count + pending == DEPTH. A transfer occurs when in_valid && in_ready.
    - Transfer with in_last=1 -> FLUSH.
    - Transfer that makes the buffer full -> FLUSH.
  - FLUSH: waits for the final write to retire; done=1 for exactly one cycle; then IDLE.
- start while in LOAD or FLUSH is ignored.
- Latency: one output register stage. A bundle accepted in cycle N produces imem_we=1 with addr/wdata in cycle N+1.
  - Back-to-back transfers sustain one word per cycle.
  - imem_we is high only in cycles following a transfer.
- Address and count:
  - imem_addr advances by 4 after each write.
  - count increments on each imem_we.
  - Both hold their final value after done until the next start.
- Encoding rules (opcode constants from package):
  - IT_LOAD (4'b0001): {imm[11:0], rs1, func3, rd, 7'b0000011}
  - IT_STORE (4'b0010): {imm[11:5], rs2, rs1, func3, imm[4:0], 7'b0100011}
  - IT_RTYPE (4'b0011): {func7, rs2, rs1, func3, rd, 7'b0110011}
  - IT_IALU (4'b0100): {imm[11:0], rs1, func3, rd, 7'b0010011}. Exception: when func3 is 3'b001 or 3'b101 (shifts), bits [31:25] = func7 and bits [24:20] = imm[4:0].
  - Any other type: writes NOP 32'h00000013, sets err (sticky until next start or rst). The write still consumes a slot.
- Fields are encoded unmodified. Ignored inputs per type are don't-care.
- busy = (state != IDLE).

Decomposition:
- Package rv32_enc_pkg:
  - inst_type enum (IT_NONE=0, IT_LOAD, IT_STORE, IT_RTYPE, IT_IALU), shared with the decoder.
  - opcode localparams OPC_LOAD, OPC_STORE, OPC_OP, OPC_OPIMM.
  - NOP constant.
- Sub-module inst_packer: purely combinational field-to-word encoder plus unsupported flag. The loader wraps it with the FSM, register stage and counters.

Test Plan:
- start; single bundle LOAD rd=5 rs1=2 f3=010 imm=0x008 last=1 -> next cycle imem_we=1, addr=0x000, wdata=0x00812283; done pulse; count=1.
- Back-to-back STORE rs2=6 rs1=2 f3=010 imm=0x00C, then RTYPE add rd=3 rs1=1 rs2=2 f7=0 -> wdata 0x00612623 @0x000, 0x002081B3 @0x004 on consecutive cycles.
- RTYPE f7=0100000 (sub x3,x1,x2) -> 0x402081B3. IALU srai rd=4 rs1=1 f3=101 f7=0100000 imm=3 -> 0x4030D213.
- inst_type=4'b1111 -> wdata=0x00000013, err=1 and stays 1 through session end; cleared on next start.
- DEPTH=4, stream 6 bundles without last -> exactly 4 writes (addr 0x0..0xC); in_ready=0 after 4th transfer; done pulse; count=4.
- rst asserted after 2 of 5 transfers -> all outputs return to reset values next cycle; no further imem_we; new start writes from BASE_ADDR.
